// File: rtl/bmem_arbiter.sv
// Shares the single banked-memory port between icache, dcache and prefetcher:
// serialises 256-bit lines into 64-bit bursts and routes read returns by address.
module bmem_arbiter (
    input  logic         clk,
    input  logic         rst,

    input  logic [31:0]  i_addr,
    input  logic         i_read,
    output logic [255:0] i_rdata,
    output logic         i_resp,

    input  logic [31:0]  d_addr,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,

    input  logic [31:0]  p_addr,
    input  logic         p_read,
    output logic [255:0] p_rdata,
    output logic         p_resp,

    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);

    localparam int unsigned LINE_BEATS = 4;
    localparam logic [1:0]  LAST_BEAT  = 2'(LINE_BEATS - 1);
    localparam int unsigned SI = 0;
    localparam int unsigned SD = 1;
    localparam int unsigned SP = 2;

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_ISSUED, S_RESP} slot_e;
    typedef enum logic [2:0] {B_IDLE, B_RD, B_WR0, B_WR1, B_WR2, B_WR3} bus_e;

    slot_e        slot_st   [3];
    logic [31:0]  slot_addr [3];
    logic [1:0]   slot_cnt  [3];
    logic [191:0] slot_buf  [3];
    logic         resp_q    [3];
    logic [255:0] rdata_q   [3];

    bus_e        bus_st;
    logic [1:0]  rd_slot;
    logic        rr_d;

    logic [31:0] req_addr [3];
    logic [2:0]  req_rd;
    logic [2:0]  req_any;
    logic [31:0] ret_addr;
    logic        unused_bits;

    logic [2:0]  cand;
    logic [2:0]  piggy;
    logic [2:0]  grantable;
    logic        wr_hazard;
    logic        bus_free;
    logic        gnt_valid;
    logic [1:0]  gnt_slot;
    logic        gnt_wr;

    assign ret_addr    = {bmem_raddr[31:5], 5'd0};
    assign unused_bits = ^{i_addr[4:0], d_addr[4:0], p_addr[4:0], bmem_raddr[4:0]};

    assign i_resp  = resp_q[SI];
    assign d_resp  = resp_q[SD];
    assign p_resp  = resp_q[SP];
    assign i_rdata = rdata_q[SI];
    assign d_rdata = rdata_q[SD];
    assign p_rdata = rdata_q[SP];

    always_comb begin
        req_addr[SI] = {i_addr[31:5], 5'd0};
        req_addr[SD] = {d_addr[31:5], 5'd0};
        req_addr[SP] = {p_addr[31:5], 5'd0};
        req_rd       = {p_read, d_read, i_read};
        req_any      = {p_read, d_read | d_write, i_read};
    end

    always_comb begin
        cand      = '0;
        piggy     = '0;
        grantable = '0;
        wr_hazard = 1'b0;
        gnt_valid = 1'b0;
        gnt_slot  = 2'(SI);
        gnt_wr    = 1'b0;
        for (int unsigned s = 0; s < 3; s++) begin
            cand[s] = req_any[s] && (slot_st[s] == S_IDLE);
        end
        // Piggyback only onto a slot that has not yet seen (or is not now seeing) beat 0.
        for (int unsigned s = 0; s < 3; s++) begin
            for (int unsigned o = 0; o < 3; o++) begin
                if (slot_st[o] == S_ISSUED && slot_addr[o] == req_addr[s] &&
                    slot_cnt[o] == 2'd0 && !(bmem_rvalid && ret_addr == slot_addr[o]) &&
                    req_rd[s] && cand[s]) begin
                    piggy[s] = 1'b1;
                end
            end
        end
        for (int unsigned o = 0; o < 3; o++) begin
            if ((slot_st[o] == S_ISSUED || slot_st[o] == S_PEND) &&
                slot_addr[o] == req_addr[SD]) begin
                wr_hazard = 1'b1;
            end
        end
        grantable     = cand & ~piggy;
        grantable[SD] = grantable[SD] && !(d_write && wr_hazard);
        bus_free      = (bus_st == B_IDLE) || (bus_st == B_RD && bmem_ready);
        if (bus_free) begin
            if (grantable[SD] && (rr_d || !grantable[SI])) begin
                gnt_valid = 1'b1;
                gnt_slot  = 2'(SD);
                gnt_wr    = d_write;
            end else if (grantable[SI]) begin
                gnt_valid = 1'b1;
                gnt_slot  = 2'(SI);
            end else if (grantable[SP]) begin
                gnt_valid = 1'b1;
                gnt_slot  = 2'(SP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < 3; s++) begin
                slot_st[s]   <= S_IDLE;
                slot_addr[s] <= '0;
                slot_cnt[s]  <= '0;
                slot_buf[s]  <= '0;
                resp_q[s]    <= 1'b0;
                rdata_q[s]   <= '0;
            end
            bus_st     <= B_IDLE;
            rd_slot    <= '0;
            rr_d       <= 1'b1;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            for (int unsigned s = 0; s < 3; s++) begin
                resp_q[s] <= 1'b0;
                case (slot_st[s])
                    S_IDLE: begin
                        if (piggy[s]) begin
                            slot_st[s]   <= S_ISSUED;
                            slot_addr[s] <= req_addr[s];
                            slot_cnt[s]  <= '0;
                        end
                    end
                    S_ISSUED: begin
                        if (bmem_rvalid && ret_addr == slot_addr[s]) begin
                            slot_cnt[s] <= slot_cnt[s] + 2'd1;
                            if (slot_cnt[s] == LAST_BEAT) begin
                                slot_st[s] <= S_RESP;
                                resp_q[s]  <= 1'b1;
                                rdata_q[s] <= {bmem_rdata, slot_buf[s]};
                            end else begin
                                case (slot_cnt[s])
                                    2'd0:    slot_buf[s][63:0]    <= bmem_rdata;
                                    2'd1:    slot_buf[s][127:64]  <= bmem_rdata;
                                    default: slot_buf[s][191:128] <= bmem_rdata;
                                endcase
                            end
                        end
                    end
                    S_RESP:  slot_st[s] <= S_IDLE;
                    default: ;
                endcase
            end

            case (bus_st)
                B_RD: begin
                    if (bmem_ready) begin
                        slot_st[rd_slot]  <= S_ISSUED;
                        slot_cnt[rd_slot] <= '0;
                        bmem_read         <= 1'b0;
                        bus_st            <= B_IDLE;
                    end
                end
                B_WR0: if (bmem_ready) begin bus_st <= B_WR1; bmem_wdata <= d_wdata[127:64];  end
                B_WR1: if (bmem_ready) begin bus_st <= B_WR2; bmem_wdata <= d_wdata[191:128]; end
                B_WR2: if (bmem_ready) begin bus_st <= B_WR3; bmem_wdata <= d_wdata[255:192]; end
                B_WR3: begin
                    if (bmem_ready) begin
                        bus_st      <= B_IDLE;
                        bmem_write  <= 1'b0;
                        slot_st[SD] <= S_RESP;
                        resp_q[SD]  <= 1'b1;
                    end
                end
                default: ;
            endcase

            // A grant overrides the idle transition of a read accepted this cycle.
            if (gnt_valid) begin
                slot_st[gnt_slot]   <= S_PEND;
                slot_addr[gnt_slot] <= req_addr[gnt_slot];
                bmem_addr           <= req_addr[gnt_slot];
                if (gnt_wr) begin
                    bus_st     <= B_WR0;
                    bmem_write <= 1'b1;
                    bmem_wdata <= d_wdata[63:0];
                end else begin
                    bus_st    <= B_RD;
                    bmem_read <= 1'b1;
                    rd_slot   <= gnt_slot;
                end
                if (gnt_slot != 2'(SP)) begin
                    rr_d <= (gnt_slot == 2'(SI));
                end
            end
        end
    end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: hand-driven memory returns, logged bmem
// handshakes and responses checked against hand-computed values.
module tb_bmem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_addr, d_addr, p_addr;
    logic         i_read, d_read, d_write, p_read;
    logic [255:0] d_wdata;
    logic [255:0] i_rdata, d_rdata, p_rdata;
    logic         i_resp, d_resp, p_resp;
    logic [31:0]  bmem_addr, bmem_raddr;
    logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [63:0]  bmem_wdata, bmem_rdata;

    bmem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .p_addr(p_addr), .p_read(p_read), .p_rdata(p_rdata), .p_resp(p_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    int unsigned  cyc = 0;
    logic [31:0]  rd_addrs [$];
    int unsigned  rd_cyc   [$];
    logic [63:0]  wr_data  [$];
    int unsigned  wr_cyc   [$];
    int unsigned  resp_n   [3];
    int unsigned  resp_cyc [3];
    logic [255:0] resp_line[3];
    int unsigned  last_beat_cyc;

    // Log bmem handshakes and responses; the log is cleared while reset is high.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            rd_addrs.delete(); rd_cyc.delete(); wr_data.delete(); wr_cyc.delete();
            for (int i = 0; i < 3; i++) begin resp_n[i] = 0; resp_cyc[i] = 0; resp_line[i] = '0; end
        end else begin
            if (bmem_read && bmem_ready) begin rd_addrs.push_back(bmem_addr); rd_cyc.push_back(cyc); end
            if (bmem_write && bmem_ready) begin wr_data.push_back(bmem_wdata); wr_cyc.push_back(cyc); end
            if (i_resp) begin resp_n[0]++; resp_cyc[0] = cyc; resp_line[0] = i_rdata; end
            if (d_resp) begin resp_n[1]++; resp_cyc[1] = cyc; resp_line[1] = d_rdata; end
            if (p_resp) begin resp_n[2]++; resp_cyc[2] = cyc; resp_line[2] = p_rdata; end
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Requesters drop their request on seeing their response.
    task automatic tick();
        @(negedge clk);
        if (i_resp) i_read = 1'b0;
        if (d_resp) begin d_read = 1'b0; d_write = 1'b0; end
        if (p_resp) p_read = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_addr = '0; d_addr = '0; p_addr = '0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; p_read = 1'b0;
        d_wdata = '0; bmem_ready = 1'b1; bmem_rvalid = 1'b0;
        bmem_raddr = '0; bmem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_rd(input string tag, input int unsigned n);
        int unsigned k = 0;
        while (rd_addrs.size() < n && k < 50) begin tick(); k++; end
        if (rd_addrs.size() < n) check(tag, 256'(rd_addrs.size()), 256'(n));
    endtask

    task automatic wait_resp(input string tag, input int unsigned which, input int unsigned n);
        int unsigned k = 0;
        while (resp_n[which] < n && k < 50) begin tick(); k++; end
        if (resp_n[which] < n) check(tag, 256'(resp_n[which]), 256'(n));
    endtask

    task automatic send_line(input logic [31:0] a, input logic [255:0] line);
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = a;
            bmem_rdata  = line[64*k +: 64];
            if (k == 3) last_beat_cyc = cyc;
            tick();
        end
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
    endtask

    function automatic logic [255:0] pat_line(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[64*k +: 64] = {a, 24'hC0FFEE, 8'(k)};
        return l;
    endfunction

    initial begin
        logic [255:0] t1_line, w_line;
        int unsigned  t;

        // Reset state
        do_reset();
        check("rst_i_resp", 256'(i_resp), 256'(0));
        check("rst_d_resp", 256'(d_resp), 256'(0));
        check("rst_p_resp", 256'(p_resp), 256'(0));
        check("rst_bmem_read", 256'(bmem_read), 256'(0));
        check("rst_bmem_write", 256'(bmem_write), 256'(0));
        check("rst_bmem_addr", 256'(bmem_addr), 256'(0));
        check("rst_bmem_wdata", 256'(bmem_wdata), 256'(0));
        check("rst_rdata", i_rdata | d_rdata | p_rdata, '0);

        // Single I read
        do_reset();
        t1_line = {64'h4444444444444444, 64'h3333333333333333,
                   64'h2222222222222222, 64'h1111111111111111};
        t = cyc;
        i_addr = 32'h60000040; i_read = 1'b1;
        wait_rd("t1_rd_timeout", 1);
        tick();
        send_line(32'h60000040, t1_line);
        wait_resp("t1_resp_timeout", 0, 1);
        tick(); tick();
        check("t1_rd_count", 256'(rd_addrs.size()), 256'(1));
        check("t1_rd_addr", 256'(rd_addrs[0]), 256'(32'h60000040));
        check("t1_rd_cycle", 256'(rd_cyc[0]), 256'(t + 1));
        check("t1_resp_count", 256'(resp_n[0]), 256'(1));
        check("t1_resp_cycle", 256'(resp_cyc[0]), 256'(last_beat_cyc + 1));
        check("t1_rdata", resp_line[0], t1_line);

        // Simultaneous I and D reads, I returned first
        do_reset();
        t = cyc;
        i_addr = 32'h60000000; i_read = 1'b1;
        d_addr = 32'h60001000; d_read = 1'b1;
        wait_rd("t2_rd_timeout", 2);
        check("t2_first_addr", 256'(rd_addrs[0]), 256'(32'h60001000));
        check("t2_first_cycle", 256'(rd_cyc[0]), 256'(t + 1));
        check("t2_second_addr", 256'(rd_addrs[1]), 256'(32'h60000000));
        check("t2_second_cycle", 256'(rd_cyc[1]), 256'(t + 2));
        send_line(32'h60000000, pat_line(32'h60000000));
        send_line(32'h60001000, pat_line(32'h60001000));
        wait_resp("t2_d_timeout", 1, 1);
        check("t2_i_before_d", 256'(resp_cyc[0] < resp_cyc[1]), 256'(1));
        check("t2_i_rdata", resp_line[0], pat_line(32'h60000000));
        check("t2_d_rdata", resp_line[1], pat_line(32'h60001000));

        // D write with a 3-cycle stall at beat 2, concurrent I read
        do_reset();
        w_line = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
                  64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
        d_addr = 32'h60000080; d_write = 1'b1; d_wdata = w_line;
        i_addr = 32'h60000200; i_read = 1'b1;
        tick(); tick(); tick();
        bmem_ready = 1'b0;
        check("t3_stall_wdata0", 256'(bmem_wdata), 256'(64'hCCCCCCCCCCCCCCCC));
        tick();
        check("t3_stall_wdata1", 256'(bmem_wdata), 256'(64'hCCCCCCCCCCCCCCCC));
        tick();
        check("t3_stall_wdata2", 256'(bmem_wdata), 256'(64'hCCCCCCCCCCCCCCCC));
        tick();
        bmem_ready = 1'b1;
        check("t3_stall_write", 256'(bmem_write), 256'(1));
        wait_resp("t3_d_timeout", 1, 1);
        wait_rd("t3_rd_timeout", 1);
        check("t3_beats", 256'(wr_data.size()), 256'(4));
        check("t3_wdata", {wr_data[3], wr_data[2], wr_data[1], wr_data[0]}, w_line);
        check("t3_resp_cycle", 256'(resp_cyc[1]), 256'(wr_cyc[3] + 1));
        check("t3_i_after_resp", 256'(rd_cyc[0] > resp_cyc[1]), 256'(1));
        tick();
        send_line(32'h60000200, pat_line(32'h60000200));
        wait_resp("t3_i_timeout", 0, 1);
        check("t3_i_rdata", resp_line[0], pat_line(32'h60000200));

        // P read outstanding, I piggybacks on the same line
        do_reset();
        p_addr = 32'h60000100; p_read = 1'b1;
        wait_rd("t4_rd_timeout", 1);
        i_addr = 32'h60000100; i_read = 1'b1;
        tick(); tick();
        send_line(32'h60000100, pat_line(32'h60000100));
        wait_resp("t4_i_timeout", 0, 1);
        wait_resp("t4_p_timeout", 2, 1);
        tick();
        check("t4_rd_count", 256'(rd_addrs.size()), 256'(1));
        check("t4_same_cycle", 256'(resp_cyc[0]), 256'(resp_cyc[2]));
        check("t4_same_data", resp_line[0], resp_line[2]);
        check("t4_p_rdata", resp_line[2], pat_line(32'h60000100));

        // D write hazard against an outstanding P read of the same line
        do_reset();
        p_addr = 32'h60000100; p_read = 1'b1;
        wait_rd("t5_rd_timeout", 1);
        d_addr = 32'h60000100; d_write = 1'b1; d_wdata = w_line;
        tick(); tick(); tick();
        check("t5_no_early_write", 256'(wr_data.size()), 256'(0));
        send_line(32'h60000100, pat_line(32'h60000100));
        wait_resp("t5_d_timeout", 1, 1);
        check("t5_write_after_presp", 256'(wr_cyc[0] > resp_cyc[2]), 256'(1));
        check("t5_wdata", {wr_data[3], wr_data[2], wr_data[1], wr_data[0]}, w_line);

        // Reset in the middle of a write burst
        do_reset();
        d_addr = 32'h60000080; d_write = 1'b1; d_wdata = w_line;
        tick(); tick();
        check("t6_in_wr1", 256'(bmem_write), 256'(1));
        rst = 1'b1; d_write = 1'b0;
        tick();
        check("t6_write_cleared", 256'(bmem_write), 256'(0));
        check("t6_resp_cleared", 256'({i_resp, d_resp, p_resp}), 256'(0));
        check("t6_wdata_cleared", 256'(bmem_wdata), 256'(0));
        rst = 1'b0;
        i_addr = 32'h60000300; i_read = 1'b1;
        wait_rd("t6_rd_timeout", 1);
        tick();
        send_line(32'h60000300, pat_line(32'h60000300));
        wait_resp("t6_i_timeout", 0, 1);
        check("t6_rd_addr", 256'(rd_addrs[0]), 256'(32'h60000300));
        check("t6_no_write", 256'(wr_data.size()), 256'(0));
        check("t6_i_rdata", resp_line[0], pat_line(32'h60000300));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
